// File: rtl/block_config_loader.sv
// Sequential configuration loader. It assembles WORD_W-bit words into a MEM_SIZE-bit image,
// then strobes each latch block's comb_set in turn, with a one-cycle hold after every strobe.
module block_config_loader #(
    parameter  int MEM_SIZE   = 16,
    parameter  int WORD_W     = 4,
    parameter  int NUM_BLOCKS = 4,
    parameter  int SET_CYCLES = 2,
    localparam int BLK_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cfg_valid,
    input  logic [WORD_W-1:0]     cfg_data,
    output logic                  cfg_ready,
    output logic [MEM_SIZE-1:0]   config_in,
    output logic [NUM_BLOCKS-1:0] comb_set,
    output logic [BLK_W-1:0]      blk_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int WORDS  = MEM_SIZE / WORD_W;
    localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SC_W   = (SET_CYCLES > 1) ? $clog2(SET_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SET,
        HOLD,
        DONE
    } state_t;

    state_t            state;
    logic [WCNT_W-1:0] word_cnt;
    logic [SC_W-1:0]   set_cnt;

    // Decoded from state alone, so a word source may wait for ready before raising valid.
    assign cfg_ready = (state == LOAD);

    // NOTE: sequential state uses non-blocking assignments only; config_in is a flop
    // register (not a RAM), so it is cleared by the asynchronous reset like the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            config_in <= '0;
            comb_set  <= '0;
            blk_idx   <= '0;
            word_cnt  <= '0;
            set_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        blk_idx  <= '0;
                        word_cnt <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end

                LOAD: begin
                    if (abort) begin
                        state    <= IDLE;
                        word_cnt <= '0;
                        busy     <= 1'b0;
                    end else if (cfg_valid) begin
                        config_in[int'(word_cnt) * WORD_W +: WORD_W] <= cfg_data;
                        if (word_cnt == WCNT_W'(WORDS - 1)) begin
                            state    <= SET;
                            set_cnt  <= '0;
                            comb_set <= NUM_BLOCKS'(1) << blk_idx;
                        end else begin
                            word_cnt <= word_cnt + WCNT_W'(1);
                        end
                    end
                end

                SET: begin
                    if (abort) begin
                        state    <= IDLE;
                        comb_set <= '0;
                        word_cnt <= '0;
                        busy     <= 1'b0;
                    end else if (set_cnt == SC_W'(SET_CYCLES - 1)) begin
                        state    <= HOLD;
                        comb_set <= '0;
                    end else begin
                        set_cnt <= set_cnt + SC_W'(1);
                    end
                end

                HOLD: begin
                    if (abort) begin
                        state    <= IDLE;
                        word_cnt <= '0;
                        busy     <= 1'b0;
                    end else if (blk_idx == BLK_W'(NUM_BLOCKS - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= LOAD;
                        blk_idx  <= blk_idx + BLK_W'(1);
                        word_cnt <= '0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    comb_set <= '0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_config_loader.sv
// Self-checking bench for block_config_loader (MEM_SIZE=16, WORD_W=4, NUM_BLOCKS=2, SET_CYCLES=2).
// The expected image is modelled as a plain 16-bit value that is nibble-updated on each accepted word.
module tb_block_config_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        cfg_valid;
    logic [3:0]  cfg_data;
    logic        cfg_ready;
    logic [15:0] config_in;
    logic [1:0]  comb_set;
    logic [0:0]  blk_idx;
    logic        busy;
    logic        done;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_cfg  = '0;

    block_config_loader #(
        .MEM_SIZE(16), .WORD_W(4), .NUM_BLOCKS(2), .SET_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .config_in(config_in), .comb_set(comb_set), .blk_idx(blk_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs and observations both happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status vector observed as {comb_set, cfg_ready, busy, done}.
    task automatic chk_status(input string name, input logic [4:0] want);
        checks++;
        if ({comb_set, cfg_ready, busy, done} !== want) begin
            failures++;
            $display("FAIL %s status got=%b want=%b (set,ready,busy,done)", name,
                     {comb_set, cfg_ready, busy, done}, want);
        end
    endtask

    task automatic chk_cfg(input string name);
        checks++;
        if (config_in !== exp_cfg) begin
            failures++;
            $display("FAIL %s config_in got=%h want=%h", name, config_in, exp_cfg);
        end
    endtask

    task automatic chk_blk(input string name, input int want);
        checks++;
        if (blk_idx !== 1'(want)) begin
            failures++;
            $display("FAIL %s blk_idx got=%0d want=%0d", name, blk_idx, want);
        end
    endtask

    // Present one valid word for one cycle; in LOAD it is always accepted.
    task automatic feed_word(input int k, input logic [3:0] w);
        cfg_valid = 1'b1;
        cfg_data  = w;
        tick();
        exp_cfg[k*4 +: 4] = w;
        cfg_valid = 1'b0;
        cfg_data  = 4'($urandom);
    endtask

    // Full two-block load from IDLE/DONE with up to gap_max idle cycles before every word.
    task automatic do_sequence(input string name, input logic [15:0] img [2], input int gap_max);
        logic [1:0] es;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_status({name, "_start"}, 5'b00_1_1_0);
        chk_blk({name, "_start"}, 0);
        chk_cfg({name, "_start"});
        for (int b = 0; b < 2; b++) begin
            es = 2'b01 << b;
            for (int k = 0; k < 4; k++) begin
                for (int g = $urandom_range(gap_max, 0); g > 0; g--) begin
                    tick();
                    chk_status({name, "_stall"}, 5'b00_1_1_0);
                    chk_cfg({name, "_stall"});
                end
                feed_word(k, img[b][k*4 +: 4]);
                chk_cfg({name, "_word"});
                if (k < 3) chk_status({name, "_word"}, 5'b00_1_1_0);
            end
            for (int s = 0; s < 2; s++) begin
                chk_status({name, "_set"}, {es, 3'b0_1_0});
                chk_blk({name, "_set"}, b);
                chk_cfg({name, "_set"});
                tick();
            end
            chk_status({name, "_hold"}, 5'b00_0_1_0);
            chk_cfg({name, "_hold"});
            tick();
            if (b == 0) begin
                chk_status({name, "_next"}, 5'b00_1_1_0);
                chk_blk({name, "_next"}, 1);
            end
        end
        chk_status({name, "_done"}, 5'b00_0_0_1);
        chk_cfg({name, "_done"});
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        #3;
        exp_cfg = '0;
        chk_status("reset", 5'b00_0_0_0);
        chk_cfg("reset");
        chk_blk("reset", 0);
        #9 rst_n = 1'b1;
    endtask

    task automatic test_full_load();
        logic [15:0] img [2];
        img[0] = 16'h4321;
        img[1] = 16'hDCBA;
        do_sequence("full", img, 0);
        checks++;
        if (config_in !== 16'hDCBA) begin
            failures++;
            $display("FAIL full_final config_in got=%h want=DCBA", config_in);
        end
    endtask

    task automatic test_restart_from_done();
        logic [15:0] img [2];
        img[0] = 16'h9E57;
        img[1] = 16'h0F61;
        do_sequence("restart", img, 2);
    endtask

    task automatic test_stall_random();
        logic [15:0] img [2];
        for (int r = 0; r < 4; r++) begin
            img[0] = 16'($urandom);
            img[1] = 16'($urandom);
            do_sequence("stall", img, 3);
        end
    endtask

    task automatic test_start_while_busy();
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_word(0, 4'h5);
        feed_word(1, 4'h6);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_status("busy_start", 5'b00_1_1_0);
        chk_blk("busy_start", 0);
        feed_word(2, 4'h7);
        chk_status("busy_word3", 5'b00_1_1_0);
        feed_word(3, 4'h8);
        chk_status("busy_word4", 5'b01_0_1_0);
        chk_cfg("busy_word4");
        repeat (3) tick();
        chk_status("busy_blk1", 5'b00_1_1_0);
        // Abort wins over start and over a valid word on the same edge.
        abort = 1'b1; start = 1'b1; cfg_valid = 1'b1; cfg_data = ~exp_cfg[3:0];
        tick();
        abort = 1'b0; start = 1'b0; cfg_valid = 1'b0;
        chk_status("load_abort", 5'b00_0_0_0);
        chk_cfg("load_abort");
    endtask

    task automatic test_abort();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) feed_word(k, 4'($urandom));
        chk_status("abort_set1", 5'b01_0_1_0);
        abort = 1'b1;
        tick();
        chk_status("abort_set", 5'b00_0_0_0);
        chk_cfg("abort_set");
        tick();
        chk_status("abort_idle", 5'b00_0_0_0);
        abort = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_status("abort_restart", 5'b00_1_1_0);
        chk_blk("abort_restart", 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_set();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) feed_word(k, 4'($urandom_range(15, 1)));
        chk_status("rst_preset", 5'b01_0_1_0);
        rst_n = 1'b0;
        #1;
        exp_cfg = '0;
        chk_status("rst_midset", 5'b00_0_0_0);
        chk_cfg("rst_midset");
        chk_blk("rst_midset", 0);
        #2 rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_status("rst_first_start", 5'b00_1_1_0);
        chk_blk("rst_first_start", 0);
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_restart_from_done();
        test_stall_random();
        test_start_while_busy();
        test_abort();
        test_reset_mid_set();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_config_loader.md
BLOCK_CONFIG_LOADER -- requirements
Module: block_config_loader

Interface
REQ-001 The module SHALL have parameter MEM_SIZE, default 16, giving the number of config bits per latch block.
REQ-002 The module SHALL have parameter WORD_W, default 4, giving the input config word width; MEM_SIZE SHALL be an integer multiple of WORD_W.
REQ-003 The module SHALL have parameter NUM_BLOCKS, default 4, giving the number of latch blocks programmed in sequence.
REQ-004 The module SHALL have parameter SET_CYCLES, default 2 (minimum 1), giving the number of cycles comb_set is held per block.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port start, input, 1 bit: begins a full load sequence.
REQ-008 The module SHALL have port abort, input, 1 bit: synchronous cancel of a load in progress.
REQ-009 The module SHALL have port cfg_valid, input, 1 bit: cfg_data holds a valid word.
REQ-010 The module SHALL have port cfg_data, input, WORD_W bits: config word.
REQ-011 The module SHALL have port cfg_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-012 The module SHALL have port config_in, output, MEM_SIZE bits: assembled config image driven to every latch block.
REQ-013 The module SHALL have port comb_set, output, NUM_BLOCKS bits: one-hot set strobe, bit i drives block i.
REQ-014 The module SHALL have port blk_idx, output, clog2(NUM_BLOCKS) bits (minimum 1): block currently being loaded or set.
REQ-015 The module SHALL have port busy, output, 1 bit: high in LOAD, SET and HOLD.
REQ-016 The module SHALL have port done, output, 1 bit: high in DONE.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, SET, HOLD and DONE.
REQ-018 A word SHALL be accepted only on a rising edge where cfg_valid and cfg_ready are both 1.
REQ-019 cfg_ready SHALL be 1 only in LOAD and SHALL be combinational from state only, never from cfg_valid.
REQ-020 Word k (k = 0 .. MEM_SIZE/WORD_W-1) of a block SHALL be written to config_in[k*WORD_W +: WORD_W], so the first word lands in the LSBs.
REQ-021 config_in bits not yet written for the current block SHALL retain their previous values.
REQ-022 On start=1 in IDLE or DONE, the FSM SHALL go to LOAD with blk_idx=0, word count 0 and done=0 on the next cycle.
REQ-023 start SHALL be ignored in LOAD, SET and HOLD.
REQ-024 Acceptance of the last word of a block SHALL move the FSM to SET on the next cycle.
REQ-025 In SET, comb_set SHALL equal 1<<blk_idx for exactly SET_CYCLES consecutive cycles, then the FSM SHALL go to HOLD.
REQ-026 In HOLD (exactly 1 cycle), comb_set SHALL be 0, cfg_ready SHALL be 0, and config_in SHALL be unchanged.
REQ-027 From HOLD, the FSM SHALL go to DONE if blk_idx==NUM_BLOCKS-1; otherwise it SHALL go to LOAD with blk_idx+1 and word count 0.
REQ-028 config_in SHALL be constant from the last-word acceptance through the end of HOLD.
REQ-029 comb_set SHALL be all-zero in every state other than SET.
REQ-030 abort=1 in LOAD, SET or HOLD SHALL force the FSM to IDLE on the next edge, with comb_set=0 and word count 0; config_in is retained.
REQ-031 abort SHALL take priority over start and over word acceptance in the same cycle.
REQ-032 abort in IDLE or DONE SHALL have no effect.
REQ-033 cfg_valid=0 during LOAD SHALL stall the FSM indefinitely with no timeout.

Reset
REQ-034 rst_n=0 SHALL immediately force state=IDLE, config_in=0, comb_set=0, blk_idx=0, word count 0, cfg_ready=0, busy=0 and done=0, independent of clk.
REQ-035 Reset asserted mid-SET SHALL drop comb_set to 0 asynchronously.
REQ-036 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Verification
(Parameters for all scenarios: MEM_SIZE=16, WORD_W=4, NUM_BLOCKS=2, SET_CYCLES=2.)
REQ-037 Full load: start, then words 1,2,3,4 back-to-back -> config_in=16'h4321; comb_set=2'b01 for 2 cycles; 1 HOLD cycle; then block 1 with words A,B,C,D -> config_in=16'hDCBA, comb_set=2'b10 for 2 cycles; done=1.
REQ-038 Stalled valid: idle cycles inserted between words -> same final values as REQ-037; cfg_ready stays 1 throughout LOAD; comb_set never asserts early.
REQ-039 Abort: abort during block-0 SET cycle 1 -> next cycle comb_set=0, state IDLE, busy=0; a subsequent start restarts at blk_idx=0.
REQ-040 Reset: rst_n low mid-SET -> comb_set=0 and config_in=0 before the next clk edge.
REQ-041 Start while busy: start pulsed in LOAD after 2 words -> ignored; the word count continues to 3.
REQ-042 Restart from DONE: start in DONE -> done=0 and LOAD with blk_idx=0 next cycle; config_in keeps 16'hDCBA until the first new word is accepted.
